// File: rtl/mips_multicycle_if.sv
// Memory bus between the multicycle core (master) and its memory (slave).
// A request completes at the clock edge where mem_req and mem_ack are both 1.
interface mips_multicycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mips_multicycle.sv
// Multicycle MIPS subset core (FETCH/DECODE/EXEC/MEM/WB/HALT) with a single
// req/ack memory port shared between instruction fetch and data access.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC        = 32'h0000_3000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic              clk,
  input  logic              PcReSet,
  mips_multicycle_if.master mem,
  output logic [31:0]       PC,
  output logic [31:0]       Instruction,
  output logic              retire,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2a;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_wdata;
  logic [31:0] r_maddr;
  logic [4:0]  r_wreg;
  logic        r_illegal;
  logic [31:0] r_regs [0:31];

  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [31:0] w_simm;
  logic [31:0] w_maddr;
  logic [31:0] w_alu;
  logic [4:0]  w_dest;
  logic        w_is_alu;
  logic        w_is_jr;
  logic        w_is_beq;
  logic        w_is_j;
  logic        w_is_jal;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_bad_op;
  logic        w_misaligned;
  logic        w_bad;
  logic        w_req;
  logic        w_we;
  logic        w_retire;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_imm   = r_ir[15:0];
  assign w_simm  = {{16{w_imm[15]}}, w_imm};
  assign w_maddr = r_a + w_simm;

  // Instruction decode and ALU result, evaluated from IR and the operand latches
  always_comb begin
    w_is_alu = 1'b0;
    w_is_jr  = 1'b0;
    w_is_beq = 1'b0;
    w_is_j   = 1'b0;
    w_is_jal = 1'b0;
    w_is_lw  = 1'b0;
    w_is_sw  = 1'b0;
    w_bad_op = 1'b0;
    w_alu    = 32'h0000_0000;
    w_dest   = w_rt;
    case (w_op)
      OP_RTYPE: begin
        w_dest = w_rd;
        case (w_funct)
          FN_ADDU: begin w_is_alu = 1'b1; w_alu = r_a + r_b; end
          FN_SUBU: begin w_is_alu = 1'b1; w_alu = r_a - r_b; end
          FN_SLT:  begin w_is_alu = 1'b1; w_alu = {31'd0, ($signed(r_a) < $signed(r_b))}; end
          FN_JR:   w_is_jr = 1'b1;
          default: w_bad_op = 1'b1;
        endcase
      end
      OP_J:    w_is_j   = 1'b1;
      OP_JAL:  w_is_jal = 1'b1;
      OP_BEQ:  w_is_beq = 1'b1;
      OP_ORI:  begin w_is_alu = 1'b1; w_alu = r_a | {16'h0000, w_imm}; end
      OP_LUI:  begin w_is_alu = 1'b1; w_alu = {w_imm, 16'h0000}; end
      OP_LW:   w_is_lw  = 1'b1;
      OP_SW:   w_is_sw  = 1'b1;
      default: w_bad_op = 1'b1;
    endcase
  end

  // Misaligned accesses are rejected in EXEC so MEM never sees a bad address
  assign w_misaligned = (w_is_lw | w_is_sw) & (w_maddr[1:0] != 2'b00);
  assign w_bad        = w_bad_op | w_misaligned;

  // State register
  always_ff @(posedge clk) begin
    if (!PcReSet) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, memory request and retire decode
  always_comb begin
    w_next   = r_state;
    w_req    = 1'b0;
    w_we     = 1'b0;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem.mem_ack) begin
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_bad) begin
          if (HALT_ON_ILLEGAL) begin
            w_next = S_HALT;
          end else begin
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
        end else if (w_is_alu) begin
          w_next = S_WB;
        end else if (w_is_lw || w_is_sw) begin
          w_next = S_MEM;
        end else begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_MEM: begin
        w_req = 1'b1;
        w_we  = w_is_sw;
        if (mem.mem_ack) begin
          w_retire = w_is_sw;
          w_next   = w_is_sw ? S_FETCH : S_WB;
        end else begin
          w_next = S_MEM;
        end
      end
      S_WB: begin
        w_retire = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end

  assign mem.mem_req   = w_req & PcReSet;
  assign mem.mem_we    = w_we;
  assign mem.mem_addr  = (r_state == S_MEM) ? r_maddr : r_pc;
  assign mem.mem_wdata = r_b;
  assign PC            = r_pc;
  assign Instruction   = r_ir;
  assign retire        = w_retire & PcReSet;
  assign illegal       = r_illegal;

  // Datapath: PC, IR, operand latches, register file and sticky illegal flag
  always_ff @(posedge clk) begin
    if (!PcReSet) begin
      r_pc      <= RESET_PC;
      r_ir      <= 32'h0000_0000;
      r_a       <= 32'h0000_0000;
      r_b       <= 32'h0000_0000;
      r_wdata   <= 32'h0000_0000;
      r_maddr   <= 32'h0000_0000;
      r_wreg    <= 5'd0;
      r_illegal <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'h0000_0000;
      end
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem.mem_ack) begin
            r_ir <= mem.mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a <= (w_rs == 5'd0) ? 32'h0000_0000 : r_regs[w_rs];
          r_b <= (w_rt == 5'd0) ? 32'h0000_0000 : r_regs[w_rt];
        end
        S_EXEC: begin
          if (w_bad) begin
            r_illegal <= 1'b1;
          end else begin
            r_wdata <= w_alu;
            r_wreg  <= w_dest;
            r_maddr <= w_maddr;
            // r_pc already points past this instruction, giving no delay slot
            if (w_is_beq && (r_a == r_b)) begin
              r_pc <= r_pc + {w_simm[29:0], 2'b00};
            end
            if (w_is_j || w_is_jal) begin
              r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
            end
            if (w_is_jal) begin
              r_regs[31] <= r_pc;
            end
            if (w_is_jr) begin
              r_pc <= r_a;
            end
          end
        end
        S_MEM: begin
          if (mem.mem_ack && w_is_lw) begin
            r_wdata <= mem.mem_rdata;
          end
        end
        S_WB: begin
          if (r_wreg != 5'd0) begin
            r_regs[r_wreg] <= r_wdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle.sv
// Directed bench: one halting core runs a short program against a memory with
// delayed data acks; a second, non-halting core checks illegal-as-no-op.
module tb_mips_multicycle;

  logic clk;
  logic rst1;
  logic rst2;
  logic [31:0] pc1, ir1, pc2, ir2;
  logic ret1, ill1, ret2, ill2;

  mips_multicycle_if bus1 ();
  mips_multicycle_if bus2 ();

  mips_multicycle #(.RESET_PC(32'h0000_3000), .HALT_ON_ILLEGAL(1'b1)) dut1 (
    .clk(clk), .PcReSet(rst1), .mem(bus1),
    .PC(pc1), .Instruction(ir1), .retire(ret1), .illegal(ill1)
  );

  mips_multicycle #(.RESET_PC(32'h0000_3000), .HALT_ON_ILLEGAL(1'b0)) dut2 (
    .clk(clk), .PcReSet(rst2), .mem(bus2),
    .PC(pc2), .Instruction(ir2), .retire(ret2), .illegal(ill2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int DATA_DELAY = 3;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory for dut1: instruction words at 0x3000.., data words below 0x1000 with delayed ack
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:15];
  logic        patch;
  int          wait1 = 0;
  int          delay1;
  int          wr_cnt = 0;
  logic [31:0] wr_addr = 32'h0;
  logic [31:0] wr_data = 32'h0;

  assign delay1 = (bus1.mem_addr < 32'h0000_1000) ? DATA_DELAY : 0;
  assign bus1.mem_ack = bus1.mem_req && (wait1 >= delay1);
  assign bus1.mem_rdata = (bus1.mem_addr < 32'h0000_1000) ? dmem[bus1.mem_addr[5:2]] :
                          (patch && bus1.mem_addr == 32'h0000_3038) ? 32'hFC00_0000 :
                          imem[bus1.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus1.mem_req && !bus1.mem_ack) wait1 <= wait1 + 1;
    else wait1 <= 0;
    if (bus1.mem_req && bus1.mem_ack && bus1.mem_we) begin
      dmem[bus1.mem_addr[5:2]] <= bus1.mem_wdata;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= bus1.mem_addr;
      wr_data <= bus1.mem_wdata;
    end
  end

  // Memory for dut2: zero-wait, illegal opcode then misaligned lw then nops
  logic [31:0] rdata2;
  always_comb begin
    case (bus2.mem_addr)
      32'h0000_3000: rdata2 = 32'hFC00_0000;
      32'h0000_3004: rdata2 = 32'h8C08_0001;
      default:       rdata2 = 32'h3400_0000;
    endcase
  end
  assign bus2.mem_rdata = rdata2;
  assign bus2.mem_ack   = bus2.mem_req;

  // Bus monitors sampled on the falling edge
  logic        prev_pend = 1'b0;
  logic        prev_we;
  logic [31:0] prev_addr, prev_wdata;
  int unstable_cnt = 0, stall_cnt = 0, skip_cnt = 0;
  int halt_req_cnt = 0, halt_ret_cnt = 0, data_req2 = 0;
  logic halt_watch;

  always @(negedge clk) begin
    if (rst1 && prev_pend) begin
      stall_cnt <= stall_cnt + 1;
      if (!bus1.mem_req || bus1.mem_we !== prev_we || bus1.mem_addr !== prev_addr ||
          bus1.mem_wdata !== prev_wdata)
        unstable_cnt <= unstable_cnt + 1;
    end
    prev_pend  <= rst1 && bus1.mem_req && !bus1.mem_ack;
    prev_we    <= bus1.mem_we;
    prev_addr  <= bus1.mem_addr;
    prev_wdata <= bus1.mem_wdata;
    if (rst1 && bus1.mem_req && bus1.mem_ack && !bus1.mem_we &&
        (bus1.mem_addr == 32'h300C || bus1.mem_addr == 32'h3028 ||
         bus1.mem_addr == 32'h3034 || bus1.mem_addr == 32'h303C))
      skip_cnt <= skip_cnt + 1;
    if (halt_watch && bus1.mem_req) halt_req_cnt <= halt_req_cnt + 1;
    if (halt_watch && ret1) halt_ret_cnt <= halt_ret_cnt + 1;
    if (rst2 && bus2.mem_req && bus2.mem_addr < 32'h0000_3000) data_req2 <= data_req2 + 1;
  end

  // Wait (bounded) for the next retire, check its latency, then the PC in the following fetch
  task automatic run_instr(input bit sel, input string tag, input int exp_cyc, input logic [31:0] exp_pc);
    int n;
    n = 1;
    while (!(sel ? ret2 : ret1) && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    check_val({tag, "_cycles"}, n, exp_cyc);
    @(negedge clk); #1;
    check_val({tag, "_pc"}, sel ? pc2 : pc1, exp_pc);
  endtask

  initial begin
    rst1 = 1'b0;
    rst2 = 1'b0;
    patch = 1'b0;
    halt_watch = 1'b0;
    for (int i = 0; i < 64; i++) imem[i] = 32'hFC00_0000;
    imem[0]  = 32'h3401_1234;  // 3000 ori  $1,$0,0x1234
    imem[1]  = 32'h3C02_8000;  // 3004 lui  $2,0x8000
    imem[2]  = 32'h0C00_0C04;  // 3008 jal  0x3010
    imem[4]  = 32'h0042_1821;  // 3010 addu $3,$2,$2
    imem[5]  = 32'h0040_202A;  // 3014 slt  $4,$2,$0
    imem[6]  = 32'h0001_3023;  // 3018 subu $6,$0,$1
    imem[7]  = 32'hAC01_0004;  // 301C sw   $1,4($0)
    imem[8]  = 32'h8C05_0004;  // 3020 lw   $5,4($0)
    imem[9]  = 32'h0800_0C0B;  // 3024 j    0x302C
    imem[11] = 32'h3407_3038;  // 302C ori  $7,$0,0x3038
    imem[12] = 32'h00E0_0008;  // 3030 jr   $7
    imem[14] = 32'h1000_FFFF;  // 3038 beq  $0,$0,-1

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_val("rst_pc", pc1, 32'h0000_3000);
    check_val("rst_ir", ir1, 32'h0);
    check_val("rst_illegal", 32'(ill1), 32'h0);
    check_val("rst_retire", 32'(ret1), 32'h0);
    check_val("rst_req_forced", 32'(bus1.mem_req), 32'h0);

    rst1 = 1'b1; #1;
    check_val("first_fetch_req", 32'(bus1.mem_req), 32'h1);
    check_val("first_fetch_addr", bus1.mem_addr, 32'h0000_3000);

    run_instr(1'b0, "ori",  4, 32'h3004);
    run_instr(1'b0, "lui",  4, 32'h3008);
    run_instr(1'b0, "jal",  3, 32'h3010);
    run_instr(1'b0, "addu", 4, 32'h3014);
    run_instr(1'b0, "slt",  4, 32'h3018);
    run_instr(1'b0, "subu", 4, 32'h301C);
    run_instr(1'b0, "sw",   7, 32'h3020);
    check_val("sw_count", wr_cnt, 32'd1);
    check_val("sw_addr", wr_addr, 32'h0000_0004);
    check_val("sw_data", wr_data, 32'h0000_1234);
    run_instr(1'b0, "lw",   8, 32'h3024);
    check_val("lw_ir", ir1, 32'h8C05_0004);
    run_instr(1'b0, "j",    3, 32'h302C);
    run_instr(1'b0, "ori7", 4, 32'h3030);
    run_instr(1'b0, "jr",   3, 32'h3038);
    run_instr(1'b0, "beq1", 3, 32'h3038);
    run_instr(1'b0, "beq2", 3, 32'h3038);

    check_val("reg0",  dut1.r_regs[0],  32'h0000_0000);
    check_val("reg1",  dut1.r_regs[1],  32'h0000_1234);
    check_val("reg2",  dut1.r_regs[2],  32'h8000_0000);
    check_val("reg3",  dut1.r_regs[3],  32'h0000_0000);
    check_val("reg4",  dut1.r_regs[4],  32'h0000_0001);
    check_val("reg5",  dut1.r_regs[5],  32'h0000_1234);
    check_val("reg6",  dut1.r_regs[6],  32'hFFFF_EDCC);
    check_val("reg7",  dut1.r_regs[7],  32'h0000_3038);
    check_val("reg31", dut1.r_regs[31], 32'h0000_300C);
    check_val("skipped_fetches", skip_cnt, 32'd0);
    check_val("stall_cycles", stall_cnt, 32'd6);
    check_val("unstable_req", unstable_cnt, 32'd0);
    check_val("illegal_clear", 32'(ill1), 32'h0);

    // Replace the loop word with an illegal opcode; the core must halt
    patch = 1'b1;
    @(negedge clk); #1;
    halt_watch = 1'b1;
    repeat (9) @(negedge clk);
    #1;
    check_val("halt_illegal", 32'(ill1), 32'h1);
    check_val("halt_no_req", halt_req_cnt, 32'd0);
    check_val("halt_no_retire", halt_ret_cnt, 32'd0);
    check_val("halt_pc", pc1, 32'h0000_303C);
    halt_watch = 1'b0;

    rst1 = 1'b0;
    @(negedge clk); #1;
    rst1 = 1'b1; #1;
    check_val("rehalt_illegal", 32'(ill1), 32'h0);
    check_val("rehalt_pc", pc1, 32'h0000_3000);
    check_val("rehalt_req", 32'(bus1.mem_req), 32'h1);
    check_val("rehalt_addr", bus1.mem_addr, 32'h0000_3000);
    rst1 = 1'b0; #1;
    check_val("req_gated_by_reset", 32'(bus1.mem_req), 32'h0);
    @(negedge clk); #1;
    rst1 = 1'b1;

    // Non-halting core: illegal opcode and misaligned lw retire as no-ops
    rst2 = 1'b1; #1;
    check_val("d2_fetch_addr", bus2.mem_addr, 32'h0000_3000);
    run_instr(1'b1, "d2_ill", 3, 32'h3004);
    check_val("d2_illegal", 32'(ill2), 32'h1);
    run_instr(1'b1, "d2_mis", 3, 32'h3008);
    run_instr(1'b1, "d2_nop", 4, 32'h300C);
    check_val("d2_no_data_req", data_req2, 32'd0);
    check_val("d2_reg8", dut2.r_regs[8], 32'h0);
    check_val("d2_illegal_sticky", 32'(ill2), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
